// File: rtl/datapath_ctrl.sv
// ----------------------------------------------------------------------------
// datapath_ctrl
//
// Sequences a four-operand datapath that computes (A+B)-(C+D). Operand beats
// arrive one per accepted handshake. Each accepted beat fires one bit of a
// one-hot capture enable (A..D). After the fourth beat the controller checks
// that the datapath holds all four operands. It then latches the 5-bit
// result, presents it with a valid/ready handshake, and clears the datapath
// for the next operation. An abort discards the operation in progress.
//
// Ports
//   clock      system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand source has a beat on the shared operand bus
//   in_ready   beat is accepted this cycle (LOAD state, no abort)
//   dp_en      one-hot operand capture enable, bit0=A .. bit3=D
//   dp_clear   one-cycle pulse clearing the datapath operand-stored flags
//   dp_full    datapath reports all four operands stored
//   dp_result  datapath (A+B)-(C+D), 5-bit two's complement
//   abort      discard the current operation
//   res_valid  result available (PRESENT state)
//   res_ready  consumer takes the result
//   res_data   registered result
//   res_neg    registered sign of the result
//   op_count   completed result handshakes, wraps at 256
//   err        sticky: datapath was not full when the result was checked
// ----------------------------------------------------------------------------
module datapath_ctrl (
   input  logic       clock,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [3:0] dp_en,
   output logic       dp_clear,
   input  logic       dp_full,
   input  logic [4:0] dp_result,
   input  logic       abort,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [4:0] res_data,
   output logic       res_neg,
   output logic [7:0] op_count,
   output logic       err
);

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      CHECK   = 2'd1,
      PRESENT = 2'd2,
      CLEAR   = 2'd3
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] idx, idx_nxt;
   logic       capture;
   logic       count_inc;
   logic       err_set;

   // State register
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state <= LOAD;
         idx   <= 2'd0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Next state and outputs. Abort always wins over a beat or a result
   // handshake in the same cycle. It has no effect in CLEAR, which already
   // returns to LOAD.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      in_ready  = 1'b0;
      dp_en     = 4'b0000;
      dp_clear  = 1'b0;
      res_valid = 1'b0;
      capture   = 1'b0;
      count_inc = 1'b0;
      err_set   = 1'b0;

      case (state)
         LOAD: begin
            // in_ready is held low during reset. The register already sits
            // in LOAD while rst is high.
            in_ready = ~abort & ~rst;
            if (abort) begin
               state_nxt = CLEAR;
               idx_nxt   = 2'd0;
            end else if (in_valid & in_ready) begin
               dp_en = 4'b0001 << idx;
               if (idx == 2'd3) begin
                  state_nxt = CHECK;
                  idx_nxt   = 2'd0;
               end else begin
                  idx_nxt = idx + 2'd1;
               end
            end
         end

         CHECK: begin
            idx_nxt = 2'd0;
            if (abort) begin
               state_nxt = CLEAR;
            end else if (dp_full) begin
               capture   = 1'b1;
               state_nxt = PRESENT;
            end else begin
               err_set   = 1'b1;
               state_nxt = CLEAR;
            end
         end

         PRESENT: begin
            idx_nxt   = 2'd0;
            res_valid = 1'b1;
            if (abort) begin
               state_nxt = CLEAR;
            end else if (res_ready) begin
               count_inc = 1'b1;
               state_nxt = CLEAR;
            end
         end

         CLEAR: begin
            dp_clear  = 1'b1;
            state_nxt = LOAD;
            idx_nxt   = 2'd0;
         end

         default: begin
            state_nxt = LOAD;
            idx_nxt   = 2'd0;
         end
      endcase
   end

   // Result, counter and error registers
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         res_data <= 5'd0;
         res_neg  <= 1'b0;
         op_count <= 8'd0;
         err      <= 1'b0;
      end else begin
         if (capture) begin
            res_data <= dp_result;
            res_neg  <= dp_result[4];
         end
         if (count_inc) begin
            op_count <= op_count + 8'd1;
         end
         if (err_set) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: doc/datapath_ctrl.md
DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 SHALL have port: clock  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: in_valid  input  1  operand source presents a 4-bit beat on the shared d_in bus.
REQ-004 SHALL have port: in_ready  output  1  controller accepts the beat this cycle.
REQ-005 SHALL have port: dp_en  output  4  one-hot operand capture enable to datapath (bit0=A..bit3=D).
REQ-006 SHALL have port: dp_clear  output  1  clears datapath operand-stored flags.
REQ-007 SHALL have port: dp_full  input  1  datapath reports all four operands stored.
REQ-008 SHALL have port: dp_result  input  5  datapath (A+B)-(C+D), 5-bit two's complement, truncated.
REQ-009 SHALL have port: abort  input  1  synchronous request to discard the current operation.
REQ-010 SHALL have port: res_valid  output  1  result available.
REQ-011 SHALL have port: res_ready  input  1  consumer takes result.
REQ-012 SHALL have port: res_data  output  5  registered copy of dp_result.
REQ-013 SHALL have port: res_neg  output  1  registered copy of dp_result[4].
REQ-014 SHALL have port: op_count  output  8  count of completed result handshakes.
REQ-015 SHALL have port: err  output  1  sticky protocol error flag.

Function
REQ-016 SHALL implement states LOAD (with 2-bit operand index idx), CHECK, PRESENT, CLEAR.
REQ-017 In LOAD, in_ready SHALL be 1 when abort=0; 0 in all other states.
REQ-018 dp_en[idx] SHALL be 1 (others 0) only in a cycle where in_valid & in_ready; dp_en SHALL be 0 otherwise (combinational, no added latency).
REQ-019 On an accepted beat with idx<3, idx SHALL increment; with idx=3, state SHALL go to CHECK and idx SHALL return to 0.
REQ-020 In LOAD with in_valid=0, state and idx SHALL hold; beats without in_ready are not captured.
REQ-021 In CHECK (one cycle), if dp_full=1: res_data<=dp_result, res_neg<=dp_result[4], go PRESENT.
REQ-022 In CHECK with dp_full=0: err<=1, go CLEAR, no result presented.
REQ-023 res_valid SHALL be 1 exactly while in PRESENT: first asserted in the 2nd cycle after the 4th accepted beat.
REQ-024 res_data/res_neg SHALL remain stable while res_valid=1 and res_ready=0.
REQ-025 On res_valid & res_ready: op_count SHALL increment (255 wraps to 0) and state SHALL go to CLEAR.
REQ-026 In CLEAR, dp_clear SHALL be 1 for exactly one cycle; next state LOAD, idx=0; dp_clear=0 in all other states.
REQ-027 abort=1 in any state except CLEAR SHALL force next state CLEAR and idx=0; it takes priority over beat acceptance and result handshake in the same cycle (no dp_en, no op_count increment).
REQ-028 abort=1 during CLEAR SHALL have no additional effect.
REQ-029 err SHALL be set only by REQ-022 and cleared only by rst.

Reset
REQ-030 While rst=1: state LOAD, idx=0, res_data=0, res_neg=0, op_count=0, err=0, res_valid=0, in_ready=0, dp_en=0, dp_clear=0.
REQ-031 Assertion of rst mid-operation SHALL discard any partial operand load or pending result immediately; no dp_clear is issued (datapath is reset on the same reset).
REQ-032 The first cycle after rst deasserts, in_ready SHALL be 1 if abort=0.

Verification
REQ-033 Beats 5,3,2,1 back-to-back -> dp_en = 0001,0010,0100,1000 on consecutive cycles; res_valid 2 cycles after the last beat; res_data=5'b00101, res_neg=0.
REQ-034 Beats 1,2,4,3 with in_valid gaps between them -> no dp_en during gaps; res_data=5'b11100 (-4), res_neg=1.
REQ-035 res_ready held 0 for 5 cycles -> res_data stable, res_valid=1 throughout; on res_ready=1, op_count 0->1, dp_clear pulses 1 cycle, in_ready=1 in the following cycle.
REQ-036 abort after the 2nd beat -> dp_clear next cycle; the next four beats load A..D from idx 0; op_count unchanged.
REQ-037 Forced dp_full=0 in CHECK -> err=1 (sticky), no res_valid, dp_clear pulse; err clears only on rst.
REQ-038 256 complete operations -> op_count wraps to 0; rst asserted mid-LOAD -> all outputs at reset values in the same cycle.
